rect_to_polar_15_165_30: RTL and testbench
==========================================

Name: rect_to_polar_15_165_30

Overview:
- Converts an upper-half-plane rectangular point (signed x, non-negative y) into a polar radius and a quantized bearing.
- The bearing is one of the six angles 15, 45, 75, 105, 135 or 165 degrees (15 + 30n).
- This block is the inverse of the existing r*sin/r*cos fixed-angle calculator. It feeds detected target coordinates back into the angle/range bookkeeping used by the display and location logic.
- It is multi-cycle: one start pulse launches a squaring stage, then a 9-iteration bit-serial integer square root, then a single-cycle done pulse.

Parameters:
- TAN30_Q8, 148, tan(30 deg) scaled by 256 (sector boundary constant).
- TAN60_Q8, 443, tan(60 deg) scaled by 256 (sector boundary constant).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- start  in  1  request; sampled only in IDLE.
- x  in  9  signed x coordinate, two's complement, range -256..255.
- y  in  8  unsigned y coordinate, 0..255.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; r/angle outputs are valid from this cycle on.
- r  out  8  radius = floor(sqrt(x^2+y^2)), saturated to 255.
- r_sat  out  1  1 when the true floor sqrt exceeded 255.
- angle_index  out  3  sector index 0..5 (0 = 15 deg ... 5 = 165 deg).
- angle_deg  out  8  15 + 30*angle_index.

Behaviour:
- Reset value of every output is 0 (busy, done, r, r_sat, angle_index, angle_deg). Internal state is IDLE.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> ROOT.
  - ROOT runs 9 cycles (iteration counter 8 down to 0) -> DONE.
  - DONE -> IDLE.
- LOAD:
  - Register x and y.
  - Form ax = |x| (9 bits; -256 gives 256).
  - Compute sum = ax^2 + y^2 (17 bits unsigned; max 130561, no overflow).
  - Compute the sector.
- Sector rule, using unsigned products with at least 18 bits:
  - A = y*256, B = ax*TAN30_Q8, C = ax*TAN60_Q8.
  - If A < B, base = 0; else if A < C, base = 1; else base = 2.
  - If x >= 0, angle_index = base; otherwise angle_index = 5 - base.
  - Equality on a boundary resolves to the higher base (steeper angle).
  - x = 0, y > 0 gives index 2 (75 deg).
  - x = 0, y = 0 gives index 0, r = 0.
- ROOT: standard restoring bit-pair square root on the 17-bit sum, producing a 9-bit root, one result bit per cycle, MSB first.
- DONE:
  - r = root > 255 ? 255 : root[7:0].
  - r_sat = (root > 255).
  - angle_index and angle_deg are registered.
  - done = 1 for exactly this cycle.
- Latency: if start is sampled at edge 0, done is high during the cycle after edge 11. busy is high from edge 1 through the end of the DONE cycle, and low again after edge 12.
- Result outputs (r, r_sat, angle_index, angle_deg) hold their last values until the next DONE. They are not cleared at the next start.
- start while busy: ignored, no queuing. start in the same cycle as DONE: ignored. start is accepted again in the cycle after DONE (IDLE).
- x and y are sampled only at the LOAD edge. Later changes to x/y do not affect the in-flight result.
- Reset asserted mid-conversion:
  - Immediate abort to IDLE with all outputs 0.
  - No done pulse for the aborted request.
  - After reset deasserts, the next start behaves normally.

Test Plan:
- Reset released, start with x=100, y=0 -> done 11 cycles after start; r=100, r_sat=0, angle_index=0, angle_deg=15.
- x=-100, y=0 -> r=100, angle_index=5, angle_deg=165. Then x=3, y=4 -> r=5, angle_deg=45 (1024 < 1329). Then x=0, y=200 -> r=200, angle_deg=75.
- x=255, y=255 -> r=255, r_sat=1 (root 360), angle_deg=45. x=-256, y=255 -> r=255, r_sat=1, angle_deg=135.
- Boundary: x=64, y=37 (A=9472 equals B=9472) -> angle_deg=45; x=64, y=36 -> angle_deg=15; x=0, y=0 -> r=0, angle_deg=15.
- Start pulsed again at cycles 3 and 11 of a conversion -> exactly one done, for the first request only; a start one cycle after done produces a second done 11 cycles later.
- Assert reset at cycle 5 of a conversion -> all outputs 0 immediately, no done. Next start with x=6, y=8 -> r=10, angle_deg=45.

Source files
------------

// File: rtl/rect_to_polar_15_165_30_if.sv
// rtl/rect_to_polar_15_165_30_if.sv - request/result bundle for rect_to_polar_15_165_30
// Ports carried:
//   start        requester -> converter, launch pulse (honoured only when idle)
//   x, y         requester -> converter, signed x (-256..255), unsigned y (0..255)
//   busy, done   converter -> requester, in-progress flag and one-cycle completion pulse
//   r, r_sat     converter -> requester, floor(sqrt(x^2+y^2)) saturated to 255, saturation flag
//   angle_index  converter -> requester, sector 0..5
//   angle_deg    converter -> requester, 15 + 30*angle_index
interface rect_to_polar_15_165_30_if;
  logic              start;
  logic signed [8:0] x;
  logic        [7:0] y;
  logic              busy;
  logic              done;
  logic        [7:0] r;
  logic              r_sat;
  logic        [2:0] angle_index;
  logic        [7:0] angle_deg;

  modport master (
    output start, x, y,
    input  busy, done, r, r_sat, angle_index, angle_deg
  );

  modport slave (
    input  start, x, y,
    output busy, done, r, r_sat, angle_index, angle_deg
  );
endinterface

// File: rtl/rect_to_polar_15_165_30.sv
// rtl/rect_to_polar_15_165_30.sv - rectangular (x, y>=0) to radius + 30-degree-sector bearing
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-high; returns to IDLE and zeroes every output
//   bus    slave side of rect_to_polar_15_165_30_if (start/x/y in, busy/done/r/r_sat/angle out)
// Timing: start seen at edge 0 -> LOAD edge 1 -> squaring edge 2 -> root bits on edges 3..11
// -> DONE cycle follows edge 11 (done high, results valid) -> IDLE after edge 12.
module rect_to_polar_15_165_30 #(
  parameter int unsigned TAN30_Q8 = 148,
  parameter int unsigned TAN60_Q8 = 443
) (
  input  logic                            clock,
  input  logic                            reset,
  rect_to_polar_15_165_30_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, LOAD, ROOT, DONE} state_t;

  state_t      state_q, state_d;
  logic        sq_pend_q;     // first ROOT cycle is the registered squaring stage
  logic [3:0]  cnt_q;
  logic [8:0]  ax_q;
  logic [7:0]  y_q;
  logic [2:0]  idx_q;
  logic [16:0] sum_q;
  logic [9:0]  rem_q, rem_d;
  logic [8:0]  root_q, root_d;

  logic        busy_q, done_q, r_sat_q;
  logic [7:0]  r_q, angle_deg_q, deg_lut;
  logic [2:0]  angle_index_q;

  // |x| and sector decision straight from the inputs, captured at the LOAD edge
  logic [8:0]  x_u, ax_in;
  logic [17:0] a_val, b_val, c_val;
  logic [1:0]  base;
  logic [2:0]  idx_in;

  always_comb begin
    x_u    = bus.x;
    ax_in  = x_u[8] ? 9'(~x_u + 9'd1) : x_u;
    a_val  = {2'b00, bus.y, 8'h00};
    b_val  = 18'(ax_in) * 18'(TAN30_Q8);
    c_val  = 18'(ax_in) * 18'(TAN60_Q8);
    // strict less-than so a point exactly on a boundary takes the steeper sector
    if (a_val < b_val)      base = 2'd0;
    else if (a_val < c_val) base = 2'd1;
    else                    base = 2'd2;
    // the origin would otherwise fall through to base 2 since B = C = 0
    if (ax_in == 9'd0 && bus.y == 8'd0) idx_in = 3'd0;
    else if (x_u[8])                    idx_in = 3'd5 - {1'b0, base};
    else                                idx_in = {1'b0, base};
  end

  // One restoring bit-pair step: bring down the next two radicand bits, try (4*root + 1)
  logic [17:0] sum_ext;
  logic [11:0] rem_sh, trial;

  always_comb begin
    sum_ext = {1'b0, sum_q};
    rem_sh  = {rem_q, sum_ext[{cnt_q, 1'b0} +: 2]};
    trial   = {1'b0, root_q, 2'b01};
    if (rem_sh >= trial) begin
      rem_d  = 10'(rem_sh - trial);
      root_d = {root_q[7:0], 1'b1};
    end else begin
      rem_d  = rem_sh[9:0];
      root_d = {root_q[7:0], 1'b0};
    end
  end

  always_comb begin
    deg_lut = 8'd15;
    case (idx_q)
      3'd0:    deg_lut = 8'd15;
      3'd1:    deg_lut = 8'd45;
      3'd2:    deg_lut = 8'd75;
      3'd3:    deg_lut = 8'd105;
      3'd4:    deg_lut = 8'd135;
      3'd5:    deg_lut = 8'd165;
      default: deg_lut = 8'd15;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    state_d = ROOT;
      ROOT:    if (!sq_pend_q && cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sq_pend_q     <= 1'b0;
      cnt_q         <= 4'd0;
      ax_q          <= 9'd0;
      y_q           <= 8'd0;
      idx_q         <= 3'd0;
      sum_q         <= 17'd0;
      rem_q         <= 10'd0;
      root_q        <= 9'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      r_q           <= 8'd0;
      r_sat_q       <= 1'b0;
      angle_index_q <= 3'd0;
      angle_deg_q   <= 8'd0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_d == ROOT) || (state_d == DONE);
      case (state_q)
        LOAD: begin
          ax_q      <= ax_in;
          y_q       <= bus.y;
          idx_q     <= idx_in;
          sq_pend_q <= 1'b1;
        end
        ROOT: begin
          if (sq_pend_q) begin
            sum_q     <= 17'(ax_q) * 17'(ax_q) + 17'(y_q) * 17'(y_q);
            rem_q     <= 10'd0;
            root_q    <= 9'd0;
            cnt_q     <= 4'd8;
            sq_pend_q <= 1'b0;
          end else begin
            rem_q  <= rem_d;
            root_q <= root_d;
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              r_q           <= root_d[8] ? 8'hFF : root_d[7:0];
              r_sat_q       <= root_d[8];
              angle_index_q <= idx_q;
              angle_deg_q   <= deg_lut;
              done_q        <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.r           = r_q;
  assign bus.r_sat       = r_sat_q;
  assign bus.angle_index = angle_index_q;
  assign bus.angle_deg   = angle_deg_q;

endmodule

// File: tb/tb_rect_to_polar_15_165_30.sv
// tb/tb_rect_to_polar_15_165_30.sv - scoreboard bench for rect_to_polar_15_165_30
module tb_rect_to_polar_15_165_30;

  logic clock;
  logic reset;

  rect_to_polar_15_165_30_if bus ();

  rect_to_polar_15_165_30 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int r;
    int sat;
    int idx;
    int deg;
  } exp_t;

  typedef struct {
    int   x;
    int   y;
    exp_t e;
  } vec_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int xv, input int yv);
    exp_t m;
    int ax, s, rt, a, b, c, base;
    ax = (xv < 0) ? -xv : xv;
    s  = ax * ax + yv * yv;
    rt = 0;
    while ((rt + 1) * (rt + 1) <= s) rt++;
    m.r   = (rt > 255) ? 255 : rt;
    m.sat = (rt > 255) ? 1 : 0;
    a = yv * 256;
    b = ax * 148;
    c = ax * 443;
    base = (a < b) ? 0 : ((a < c) ? 1 : 2);
    if (ax == 0 && yv == 0) m.idx = 0;
    else                    m.idx = (xv < 0) ? 5 - base : base;
    m.deg = 15 + 30 * m.idx;
    return m;
  endfunction

  // scoreboard: every done pops one expectation
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 1, 0);
      end else begin
        got_e = exp_q.pop_front();
        check_eq("r",     int'(bus.r),           got_e.r);
        check_eq("r_sat", int'(bus.r_sat),       got_e.sat);
        check_eq("idx",   int'(bus.angle_index), got_e.idx);
        check_eq("deg",   int'(bus.angle_deg),   got_e.deg);
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns on the negedge after the done cycle.
  task automatic run_one(input int xv, input int yv, input exp_t e);
    int n;
    bit seen;
    bus.start = 1'b1;
    bus.x     = 9'(xv);
    bus.y     = 8'(yv);
    exp_q.push_back(e);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        check_eq("busy_load", int'(bus.busy), 0);
      end
      if (n == 2) begin
        check_eq("busy_root", int'(bus.busy), 1);
        bus.x = 9'($urandom);
        bus.y = 8'($urandom);
      end
      if (bus.done) seen = 1'b1;
    end
    check_eq("latency", n, 12);
    @(negedge clock);
    check_eq("done_pulse", int'(bus.done), 0);
    check_eq("busy_end",   int'(bus.busy), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int n;
    int d0;
    int xv, yv;
    vecs = '{
      '{x:  100, y:   0, e: '{r: 100, sat: 0, idx: 0, deg:  15}},
      '{x: -100, y:   0, e: '{r: 100, sat: 0, idx: 5, deg: 165}},
      '{x:    3, y:   4, e: '{r:   5, sat: 0, idx: 1, deg:  45}},
      '{x:    0, y: 200, e: '{r: 200, sat: 0, idx: 2, deg:  75}},
      '{x:  255, y: 255, e: '{r: 255, sat: 1, idx: 1, deg:  45}},
      '{x: -256, y: 255, e: '{r: 255, sat: 1, idx: 4, deg: 135}},
      '{x:   64, y:  37, e: '{r:  73, sat: 0, idx: 1, deg:  45}},
      '{x:   64, y:  36, e: '{r:  73, sat: 0, idx: 0, deg:  15}},
      '{x:    0, y:   0, e: '{r:   0, sat: 0, idx: 0, deg:  15}},
      '{x:   -3, y:   4, e: '{r:   5, sat: 0, idx: 4, deg: 135}},
      '{x:  -64, y: 200, e: '{r: 209, sat: 0, idx: 3, deg: 105}}
    };

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", int'(bus.busy),        0);
    check_eq("rst_done", int'(bus.done),        0);
    check_eq("rst_r",    int'(bus.r),           0);
    check_eq("rst_sat",  int'(bus.r_sat),       0);
    check_eq("rst_idx",  int'(bus.angle_index), 0);
    check_eq("rst_deg",  int'(bus.angle_deg),   0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) run_one(vecs[i].x, vecs[i].y, vecs[i].e);

    for (int k = 0; k < 8; k++) begin
      xv = int'($urandom_range(0, 511)) - 256;
      yv = int'($urandom_range(0, 255));
      run_one(xv, yv, model(xv, yv));
    end

    // extra starts mid-run and during the done cycle must be dropped
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.x     = 9'(10);
    bus.y     = 8'(20);
    exp_q.push_back(model(10, 20));
    for (n = 1; n <= 30; n++) begin
      @(negedge clock);
      bus.start = (n == 3 || n == 12) ? 1'b1 : 1'b0;
      if (n == 2) begin
        bus.x = 9'(-200);
        bus.y = 8'(7);
      end
      if (n == 12) check_eq("ign_done_at_12", int'(bus.done), 1);
    end
    bus.start = 1'b0;
    check_eq("ignored_starts_dones", done_cnt - d0, 1);
    check_eq("ignored_starts_queue", exp_q.size(), 0);

    // reset in the middle of a conversion
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.x     = 9'(50);
    bus.y     = 8'(50);
    for (n = 1; n <= 5; n++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", int'(bus.busy),        0);
    check_eq("mid_rst_done", int'(bus.done),        0);
    check_eq("mid_rst_r",    int'(bus.r),           0);
    check_eq("mid_rst_sat",  int'(bus.r_sat),       0);
    check_eq("mid_rst_idx",  int'(bus.angle_index), 0);
    check_eq("mid_rst_deg",  int'(bus.angle_deg),   0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    check_eq("aborted_no_done", done_cnt - d0, 0);
    run_one(6, 8, '{r: 10, sat: 0, idx: 1, deg: 45});

    repeat (3) @(negedge clock);
    check_eq("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
